parking_log_recorder: RTL and testbench

//  Receiving end of the car entry/exit write interface (write_entry/write_cost strobes

---
 rtl/parking_pkg.sv | 33 +++
 rtl/parking_log_fifo.sv | 87 ++++++++
 rtl/parking_log_recorder.sv | 144 ++++++++++++++
 tb/tb_parking_log_recorder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking log recorder and its FIFO.
package parking_pkg;

    localparam int TIME_W   = 10;
    localparam int CAR_ID_W = 2;
    localparam int REC_W    = 13;

    localparam logic REC_TYPE_ENTRY = 1'b0;
    localparam logic REC_TYPE_COST  = 1'b1;

    localparam logic [2:0] CAR_SEL_1 = 3'b001;
    localparam logic [2:0] CAR_SEL_2 = 3'b010;
    localparam logic [2:0] CAR_SEL_3 = 3'b100;

    typedef struct packed {
        logic                rec_type;
        logic [CAR_ID_W-1:0] car_id;
        logic [TIME_W-1:0]   data;
    } rec_t;

    // One-hot car select to car id; anything that is not a clean one-hot maps to 0.
    function automatic logic [CAR_ID_W-1:0] encode_car(input logic [2:0] sel);
        logic [CAR_ID_W-1:0] id;
        case (sel)
            CAR_SEL_1: id = 2'd1;
            CAR_SEL_2: id = 2'd2;
            CAR_SEL_3: id = 2'd3;
            default:   id = 2'd0;
        endcase
        return id;
    endfunction

endpackage

// File: rtl/parking_log_fifo.sv
// Generic circular FIFO with a registered read port. A pop of a non-empty FIFO
// presents the head record one cycle later with dout_vld high; dout holds its
// value otherwise. A push into a full FIFO is accepted only when a pop frees a
// slot in the same cycle, otherwise it is dropped and push_drop pulses.
module parking_log_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int WIDTH  = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  dout,
    output logic              dout_vld,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              push_drop
);

    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              dout_vld_q, dout_vld_d;
    logic              pop_ok, push_ok;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_FULL);
    assign count     = count_q;
    assign dout      = dout_q;
    assign dout_vld  = dout_vld_q;

    // Decide which operations take effect and compute next pointers, count and read data.
    always_comb begin
        pop_ok     = pop & ~empty;
        push_ok    = push & (~full | pop_ok);
        push_drop  = push & ~push_ok;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        dout_d     = dout_q;
        dout_vld_d = pop_ok;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            dout_d   = mem_q[rd_ptr_q];
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control and read-port registers; reset empties the FIFO immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    // Record storage; contents are meaningless outside the rd_ptr..wr_ptr window.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/parking_log_recorder.sv
// Receives entry/cost strobes, turns each rising edge into one tagged record and
// queues it in the log FIFO. Detected events are registered for one cycle before
// the push; when both strobes rise together the cost record waits one more cycle
// in a pending slot so the entry record is logged first.
module parking_log_recorder
    import parking_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int REV_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_entry,
    input  logic              write_cost,
    input  logic [TIME_W-1:0] entry_time_in,
    input  logic [TIME_W-1:0] cost_in,
    input  logic [2:0]        car_sel,
    input  logic              rd_req,
    output logic              rd_valid,
    output logic              rd_type,
    output logic [1:0]        rd_car,
    output logic [9:0]        rd_data,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic [REV_W-1:0]  total_revenue,
    output logic [7:0]        exit_count
);

    function automatic logic [REV_W-1:0] sat_add(input logic [REV_W-1:0] acc,
                                                 input logic [TIME_W-1:0] inc);
        logic [REV_W:0] sum;
        sum = {1'b0, acc} + {{(REV_W+1-TIME_W){1'b0}}, inc};
        return sum[REV_W] ? {REV_W{1'b1}} : sum[REV_W-1:0];
    endfunction

    logic              entry_prev_q, entry_prev_d;
    logic              cost_prev_q, cost_prev_d;
    logic              stage_vld_q, stage_vld_d;
    rec_t              stage_rec_q, stage_rec_d;
    logic              pend_vld_q, pend_vld_d;
    rec_t              pend_rec_q, pend_rec_d;
    logic              overflow_q, overflow_d;
    logic [REV_W-1:0]  total_q, total_d;
    logic [7:0]        exit_q, exit_d;

    logic              entry_ev, cost_ev, pend_drop;
    logic [CAR_ID_W-1:0] car_id;
    rec_t              entry_rec, cost_rec;
    logic              fifo_push, fifo_drop;
    rec_t              fifo_din, fifo_dout;

    assign entry_ev  = write_entry & ~entry_prev_q;
    assign cost_ev   = write_cost & ~cost_prev_q;
    assign car_id    = encode_car(car_sel);
    assign entry_rec = '{rec_type: REC_TYPE_ENTRY, car_id: car_id, data: entry_time_in};
    assign cost_rec  = '{rec_type: REC_TYPE_COST,  car_id: car_id, data: cost_in};

    // Event capture, push selection, pending-slot management, overflow and revenue.
    always_comb begin
        entry_prev_d = write_entry;
        cost_prev_d  = write_cost;
        stage_vld_d  = entry_ev | cost_ev;
        stage_rec_d  = entry_ev ? entry_rec : cost_rec;

        // The staged record has priority; the pending cost drains on a free cycle.
        fifo_push    = stage_vld_q | pend_vld_q;
        fifo_din     = stage_vld_q ? stage_rec_q : pend_rec_q;
        pend_vld_d   = pend_vld_q & stage_vld_q;
        pend_rec_d   = pend_rec_q;
        pend_drop    = 1'b0;
        if (entry_ev & cost_ev) begin
            if (pend_vld_d) begin
                pend_drop = 1'b1;
            end else begin
                pend_vld_d = 1'b1;
                pend_rec_d = cost_rec;
            end
        end

        overflow_d = overflow_q | fifo_drop | pend_drop;

        // Revenue counts every cost event, whether or not its record fits.
        total_d = total_q;
        exit_d  = exit_q;
        if (cost_ev) begin
            total_d = sat_add(total_q, cost_in);
            exit_d  = exit_q + 8'd1;
        end
    end

    // State registers; reset clears history, staged/pending records and statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_prev_q <= 1'b0;
            cost_prev_q  <= 1'b0;
            stage_vld_q  <= 1'b0;
            stage_rec_q  <= '0;
            pend_vld_q   <= 1'b0;
            pend_rec_q   <= '0;
            overflow_q   <= 1'b0;
            total_q      <= '0;
            exit_q       <= '0;
        end else begin
            entry_prev_q <= entry_prev_d;
            cost_prev_q  <= cost_prev_d;
            stage_vld_q  <= stage_vld_d;
            stage_rec_q  <= stage_rec_d;
            pend_vld_q   <= pend_vld_d;
            pend_rec_q   <= pend_rec_d;
            overflow_q   <= overflow_d;
            total_q      <= total_d;
            exit_q       <= exit_d;
        end
    end

    parking_log_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (REC_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .pop       (rd_req),
        .din       (fifo_din),
        .dout      (fifo_dout),
        .dout_vld  (rd_valid),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .push_drop (fifo_drop)
    );

    assign rd_type       = fifo_dout.rec_type;
    assign rd_car        = fifo_dout.car_id;
    assign rd_data       = fifo_dout.data;
    assign overflow      = overflow_q;
    assign total_revenue = total_q;
    assign exit_count    = exit_q;

endmodule

// File: tb/tb_parking_log_recorder.sv
// Self-checking bench for parking_log_recorder: directed scenarios plus a random
// mix of events and pops, checked against a record-level queue model.
module tb_parking_log_recorder;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int REV_W  = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             write_entry, write_cost;
    logic [9:0]       entry_time_in, cost_in;
    logic [2:0]       car_sel;
    logic             rd_req;
    logic             rd_valid, rd_type;
    logic [1:0]       rd_car;
    logic [9:0]       rd_data;
    logic [ADDR_W:0]  count;
    logic             empty, full, overflow;
    logic [REV_W-1:0] total_revenue;
    logic [7:0]       exit_count;

    parking_log_recorder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .REV_W(REV_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .write_entry   (write_entry),
        .write_cost    (write_cost),
        .entry_time_in (entry_time_in),
        .cost_in       (cost_in),
        .car_sel       (car_sel),
        .rd_req        (rd_req),
        .rd_valid      (rd_valid),
        .rd_type       (rd_type),
        .rd_car        (rd_car),
        .rd_data       (rd_data),
        .count         (count),
        .empty         (empty),
        .full          (full),
        .overflow      (overflow),
        .total_revenue (total_revenue),
        .exit_count    (exit_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int t;
        int car;
        int data;
    } mrec_t;

    mrec_t mq[$];
    int    m_ovf;
    int    m_rev;
    int    m_exits;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int car_of(input logic [2:0] sel);
        if (sel == 3'b001) return 1;
        if (sel == 3'b010) return 2;
        if (sel == 3'b100) return 3;
        return 0;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_ovf   = 0;
        m_rev   = 0;
        m_exits = 0;
    endtask

    task automatic model_push(input int t, input logic [2:0] sel, input int data);
        mrec_t r;
        r.t = t; r.car = car_of(sel); r.data = data;
        if (mq.size() == DEPTH) m_ovf = 1;
        else mq.push_back(r);
    endtask

    task automatic model_cost(input int c);
        m_rev = m_rev + c;
        if (m_rev > 65535) m_rev = 65535;
        m_exits = (m_exits + 1) % 256;
    endtask

    // Raise the selected strobes for 'hold' cycles, drop them, let the pipeline settle.
    task automatic do_event(input bit e, input bit c, input logic [2:0] sel,
                            input logic [9:0] tv, input logic [9:0] cv, input int hold);
        car_sel = sel; entry_time_in = tv; cost_in = cv;
        write_entry = e; write_cost = c;
        repeat (hold) step();
        write_entry = 1'b0; write_cost = 1'b0;
        repeat (3) step();
        if (e) model_push(0, sel, int'(tv));
        if (c) begin
            model_push(1, sel, int'(cv));
            model_cost(int'(cv));
        end
    endtask

    task automatic pop_check(input string tag);
        mrec_t r;
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        if (mq.size() == 0) begin
            chk({tag, "_novalid"}, 32'(rd_valid), 32'd0);
        end else begin
            r = mq.pop_front();
            chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
            chk({tag, "_type"},  32'(rd_type),  32'(r.t));
            chk({tag, "_car"},   32'(rd_car),   32'(r.car));
            chk({tag, "_data"},  32'(rd_data),  32'(r.data));
        end
        step();
        chk({tag, "_pulse"}, 32'(rd_valid), 32'd0);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_count"},    32'(count),         32'(mq.size()));
        chk({tag, "_empty"},    32'(empty),         32'(mq.size() == 0));
        chk({tag, "_full"},     32'(full),          32'(mq.size() == DEPTH));
        chk({tag, "_overflow"}, 32'(overflow),      32'(m_ovf));
        chk({tag, "_revenue"},  32'(total_revenue), 32'(m_rev));
        chk({tag, "_exits"},    32'(exit_count),    32'(m_exits));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        model_clear();
    endtask

    initial begin
        mrec_t r;
        int    op;
        reset = 1'b1; write_entry = 1'b0; write_cost = 1'b0;
        entry_time_in = '0; cost_in = '0; car_sel = '0; rd_req = 1'b0;
        model_clear();
        #3;
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_data", 32'(rd_data), 32'd0);
        check_state("rst");
        step();
        reset = 1'b0;
        step();

        // Held entry strobe gives exactly one record.
        do_event(1'b1, 1'b0, 3'b001, 10'd37, 10'd0, 5);
        check_state("hold");
        pop_check("hold_pop");
        check_state("hold_after");

        // Two cost pulses for car 3.
        do_event(1'b0, 1'b1, 3'b100, 10'd0, 10'd250, 1);
        do_event(1'b0, 1'b1, 3'b100, 10'd0, 10'd250, 1);
        chk("cost_rev", 32'(total_revenue), 32'd500);
        chk("cost_exits", 32'(exit_count), 32'd2);
        pop_check("cost_pop1");
        pop_check("cost_pop2");

        // Nine entries into an 8-deep log.
        for (int i = 0; i < 9; i++)
            do_event(1'b1, 1'b0, 3'b010, 10'(100 + i), 10'd0, 1);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd8);
        chk("fill_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 9; i++) pop_check("fill_pop");
        check_state("fill_after");

        // Push and pop in the same cycle while full.
        do_reset();
        for (int i = 0; i < 8; i++)
            do_event(1'b1, 1'b0, 3'b001, 10'(200 + i), 10'd0, 1);
        car_sel = 3'b010; entry_time_in = 10'd555; write_entry = 1'b1;
        step();
        write_entry = 1'b0; rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        r = mq.pop_front();
        chk("pp_valid", 32'(rd_valid), 32'd1);
        chk("pp_data", 32'(rd_data), 32'(r.data));
        model_push(0, 3'b010, 555);
        repeat (2) step();
        check_state("pp");
        for (int i = 0; i < 8; i++) pop_check("pp_drain");

        // Entry and cost rise together: entry first, cost one cycle later.
        do_reset();
        car_sel = 3'b001; entry_time_in = 10'd11; cost_in = 10'd22;
        write_entry = 1'b1; write_cost = 1'b1;
        step();
        chk("sim_lat0", 32'(count), 32'd0);
        write_entry = 1'b0; write_cost = 1'b0;
        step();
        chk("sim_lat1", 32'(count), 32'd1);
        step();
        chk("sim_lat2", 32'(count), 32'd2);
        model_push(0, 3'b001, 11);
        model_push(1, 3'b001, 22);
        model_cost(22);
        step();
        check_state("sim");
        pop_check("sim_pop_entry");
        pop_check("sim_pop_cost");

        // Random mix of events and pops.
        do_reset();
        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 5));
            case (op)
                0, 1: do_event(1'b1, 1'b0, 3'($urandom_range(0, 7)), 10'($urandom_range(0, 1023)),
                               10'd0, int'($urandom_range(1, 3)));
                2:    do_event(1'b0, 1'b1, 3'($urandom_range(0, 7)), 10'd0,
                               10'($urandom_range(0, 1023)), int'($urandom_range(1, 3)));
                3:    do_event(1'b1, 1'b1, 3'($urandom_range(0, 7)), 10'($urandom_range(0, 1023)),
                               10'($urandom_range(0, 1023)), int'($urandom_range(1, 3)));
                default: pop_check("rnd_pop");
            endcase
            check_state("rnd");
        end

        // Revenue saturation.
        for (int i = 0; i < 70; i++)
            do_event(1'b0, 1'b1, 3'($urandom_range(0, 7)), 10'd0, 10'd1023, 1);
        chk("sat_rev", 32'(total_revenue), 32'd65535);
        check_state("sat");

        // Drain, then pop an empty log.
        while (mq.size() > 0) pop_check("sat_drain");
        pop_check("empty_pop");
        check_state("empty");

        // Asynchronous reset in the middle of activity.
        do_event(1'b1, 1'b0, 3'b100, 10'd77, 10'd0, 1);
        do_event(1'b0, 1'b1, 3'b010, 10'd0, 10'd300, 1);
        write_entry = 1'b1; car_sel = 3'b001; entry_time_in = 10'd5;
        step();
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        chk("arst_valid", 32'(rd_valid), 32'd0);
        chk("arst_type", 32'(rd_type), 32'd0);
        chk("arst_car", 32'(rd_car), 32'd0);
        chk("arst_data", 32'(rd_data), 32'd0);
        check_state("arst");
        write_entry = 1'b0;
        step();
        reset = 1'b0;
        repeat (3) step();
        check_state("arst_after");
        pop_check("arst_pop");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
